// File: rtl/day_name_scanner.sv
// day_name_scanner: day-of-week counter (auto/manual, load) with a scanned
// multi-digit 7-segment display of the three-letter day name.
module day_name_scanner #(
    parameter int DIV    = 50000000,
    parameter int SCAN   = 1000,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              step,
    input  logic              dir,
    input  logic              load,
    input  logic [2:0]        load_day,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_sel,
    output logic [2:0]        day,
    output logic              day_pulse
);
    localparam int TW = $clog2(DIV);
    localparam int SW = SCAN > 1 ? $clog2(SCAN) : 1;
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] L_M = 7'b1110110, L_O = 7'b1111110, L_N = 7'b0010101,
                           L_T = 7'b0001111, L_U = 7'b0111110, L_E = 7'b1001111,
                           L_W = 7'b0111111, L_D = 7'b0111101, L_H = 7'b0110111,
                           L_F = 7'b1000111, L_R = 7'b0000101, L_I = 7'b0000110,
                           L_S = 7'b1011011, L_A = 7'b1110111;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;
    logic [DW-1:0] dig;
    logic          step_q;
    logic          tick;
    logic          stp;
    logic [2:0]    nday;
    logic [20:0]   word;
    logic [6:0]    glyph;
    always_comb begin
        tick = en & ~mode & (tcnt == TW'(DIV - 1));
        stp  = mode & en & step & ~step_q;
        // a rejected load (7) still blocks tick/step so the day simply holds
        nday = load ? (load_day == 3'd7 ? day : load_day)
             : (tick | stp) ? (dir ? (day == 3'd6 ? 3'd0 : day + 3'd1)
                                   : (day == 3'd0 ? 3'd6 : day - 3'd1))
             : day;
        case (day)
            3'd0:    word = {L_M, L_O, L_N};
            3'd1:    word = {L_T, L_U, L_E};
            3'd2:    word = {L_W, L_E, L_D};
            3'd3:    word = {L_T, L_H, L_U};
            3'd4:    word = {L_F, L_R, L_I};
            3'd5:    word = {L_S, L_A, L_T};
            3'd6:    word = {L_S, L_U, L_N};
            default: word = '0;
        endcase
        glyph = dig == DW'(0) ? word[20:14] : dig == DW'(1) ? word[13:7] : word[6:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            day       <= '0;
            day_pulse <= 1'b0;
            tcnt      <= '0;
            step_q    <= 1'b0;
            scnt      <= '0;
            dig       <= '0;
            seg       <= '0;
            dig_sel   <= '0;
        end else begin
            day       <= nday;
            day_pulse <= nday != day;
            tcnt      <= (mode | load | tick) ? '0 : en ? tcnt + 1'b1 : tcnt;
            step_q    <= step;
            scnt      <= scnt == SW'(SCAN - 1) ? '0 : scnt + 1'b1;
            if (scnt == SW'(SCAN - 1))
                dig <= dig == DW'(DIGITS - 1) ? '0 : dig + 1'b1;
            seg       <= glyph;
            dig_sel   <= DIGITS'(1) << dig;
        end
    end
endmodule

// File: doc/day_name_scanner.md
DAY_NAME_SCANNER -- requirements
Module: day_name_scanner

Interface
REQ-001 SHALL have parameter DIV, default 50000000, meaning clk cycles per day step in auto mode (legal range 2 or more).
REQ-002 SHALL have parameter SCAN, default 1000, meaning clk cycles each digit is displayed before the scan moves on (legal range 1 or more).
REQ-003 SHALL have parameter DIGITS, default 3, meaning the number of letters of the day name shown (legal range 1 to 3).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: high lets the day and the day divider advance.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects auto advance, 1 selects manual step.
REQ-008 SHALL have port step, input, 1 bit: manual advance request, acted on at its 0->1 edge.
REQ-009 SHALL have port dir, input, 1 bit: 1 steps forward, 0 steps backward.
REQ-010 SHALL have port load, input, 1 bit: load load_day into the day register.
REQ-011 SHALL have port load_day, input, 3 bits: day to load, 0=MON to 6=SUN.
REQ-012 SHALL have port seg, output, 7 bits: segments A..G on bits 6..0, active-high.
REQ-013 SHALL have port dig_sel, output, DIGITS bits: one-hot enable of the active digit, bit 0 = first letter.
REQ-014 SHALL have port day, output, 3 bits: current day, 0..6.
REQ-015 SHALL have port day_pulse, output, 1 bit: high for exactly one cycle after each day change.

Function
REQ-016 SHALL hold day in the range 0..6 at all times; all 7 days, FRI included, SHALL advance normally.
REQ-017 SHALL use a tick counter of width clog2(DIV) that counts while en=1 and mode=0; at DIV-1 it wraps to 0 and issues one auto tick.
REQ-018 SHALL hold the tick counter while en=0 and SHALL clear it to 0 on mode=1, on load, and on rst.
REQ-019 SHALL, in manual mode, issue one step for each cycle where step is 1 and was 0 in the previous cycle, when en=1; a level held high gives one step only.
REQ-020 SHALL, on a tick or step, move day forward (6->0 wraps) when dir=1, or backward (0->6 wraps) when dir=0.
REQ-021 SHALL give load priority over a tick or step in the same cycle, and SHALL ignore en for load.
REQ-022 SHALL reject a load_day value of 7: day holds its value and day_pulse stays 0.
REQ-023 SHALL update day on the clock edge after the qualifying cycle, and SHALL raise day_pulse in the same cycle the new day appears.
REQ-024 SHALL keep day_pulse at 0 when a load writes the value day already holds.
REQ-025 SHALL run the scan counter regardless of en.
REQ-026 SHALL increment the digit index 0..DIGITS-1 every SCAN cycles, wrapping to 0; with DIGITS=1 the index stays at 0.
REQ-027 SHALL register seg and dig_sel, so they reflect day and the digit index one cycle after those change.
REQ-028 SHALL use the day names MON TUE WED THU FRI SAT SUN; letter k of the current day is shown on digit k.
REQ-029 SHALL encode letters as ABCDEFG: M=1110110, O=1111110, N=0010101, T=0001111, U=0111110, E=1001111.
REQ-030 SHALL encode letters as ABCDEFG: W=0111111, D=0111101, H=0110111, F=1000111, R=0000101, I=0000110, S=1011011, A=1110111.
REQ-031 SHALL make dig_sel one-hot, with seg matching the selected digit.

Reset
REQ-032 SHALL, while rst=1, set day=0 (MON), the tick counter, scan counter and digit index to 0, and clear the step edge history.
REQ-033 SHALL, while rst=1, drive seg=0000000, dig_sel=0 and day_pulse=0.
REQ-034 SHALL, one cycle after rst is released, drive dig_sel=001 and seg=M (1110110) when DIGITS=3.
REQ-035 SHALL give rst priority over load, tick and step, and SHALL abandon any partial divider or scan count.

Verification (DIV=4, SCAN=2, DIGITS=3)
REQ-036 SHALL check auto wrap: rst, then en=1, mode=0, dir=1 for 28 cycles -> day steps 0,1,...,6,0 every 4 cycles, day_pulse high 7 times, FRI->SAT seen.
REQ-037 SHALL check backward wrap: day=0, dir=0, one tick -> day=6; display scan shows S, U, N (1011011, 0111110, 0010101), each for 2 cycles.
REQ-038 SHALL check manual edge: mode=1, step held high 10 cycles -> exactly one advance; en=0 with a step edge -> no change.
REQ-039 SHALL check load priority: load=1, load_day=4, with a step edge in the same cycle -> day=4 next cycle; load_day=7 -> day unchanged, day_pulse=0.
REQ-040 SHALL check mid-operation reset: rst after 3 divider cycles -> day=0, seg=0 during reset, and the next tick arrives 4 cycles after release.
